chacha_block_engine: RTL and testbench
======================================

// Module: chacha_block_engine
// PURPOSE
//  Parametrised ChaCha block function: keystream generator for the AEAD datapath.
//  Loads key/nonce/counter, runs DOUBLE_ROUNDS column+diagonal double rounds with LANES parallel quarter rounds, then adds the input state back in.
//  Emits a 512-bit keystream block over a valid/ready handshake.
//  Successor to the fixed 20-round, one-QR-at-a-time Qround FSM.
// PARAMETERS
//  DOUBLE_ROUNDS  10  double rounds per block (4=ChaCha8, 6=ChaCha12, 10=ChaCha20); must be >=1
//  LANES          4   quarter rounds per cycle; must be 1, 2 or 4, else elaboration error
//  CNT_W          16  width of blocks_done counter
// PORTS
//  clk          in   1        system clock, rising edge
//  rst_n        in   1        asynchronous active-low reset
//  in_valid     in   1        key/nonce/counter present
//  in_ready     out  1        engine accepts a job this cycle
//  key          in   256      key; word k = key[32k+:32], k=0..7
//  nonce        in   96       nonce; word n = nonce[32n+:32]
//  counter      in   32       block counter (state word 12)
//  out_valid    out  1        keystream valid
//  out_ready    in   1        consumer takes keystream
//  keystream    out  512      state word i = keystream[32i+:32]
//  busy         out  1        job accepted, not yet handed off
//  blocks_done  out  CNT_W    blocks delivered, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Reset (async assert, sync release): all outputs 0; FSM=IDLE; state regs 0.
//  - State layout: w0..3 = 61707865 3320646e 79622d32 6b206574; w4..11 = key; w12 = counter; w13..15 = nonce.
//  - FSM: IDLE -> ROUND on in_valid&&in_ready (input state latched into work and save regs);
//    ROUND -> FFWD after R = DOUBLE_ROUNDS*8/LANES cycles; FFWD -> OUT; OUT -> IDLE on out_ready.
//  - ROUND step counter 0..R-1. One step applies LANES QRs from a fixed 8-entry schedule:
//    columns (0,4,8,12)(1,5,9,13)(2,6,10,14)(3,7,11,15), then diagonals (0,5,10,15)(1,6,11,12)(2,7,8,13)(3,4,9,14).
//    The schedule index wraps at 8. All lanes in one step touch disjoint words.
//  - QR: a+=b; d^=a; d<<<=16; c+=d; b^=c; b<<<=12; a+=b; d^=a; d<<<=8; c+=d; b^=c; b<<<=7.
//    All arithmetic is mod 2^32; no carries are kept.
//  - FFWD: keystream word i = work[i] + save[i] mod 2^32. It is registered, and out_valid is set on that edge.
//  - Latency: out_valid rises R+2 edges after the accepting edge (default 22).
//  - in_ready = (state==IDLE) || (state==OUT && out_ready). A back-to-back accept in OUT goes straight to ROUND.
//  - out_valid holds until out_ready. keystream must stay stable while out_valid && !out_ready.
//  - blocks_done increments once per out_valid&&out_ready. It wraps from all-ones to 0.
//  - busy = (state != IDLE).
//  - in_valid while not in_ready is ignored; inputs are sampled only on the accepting edge.
//  - rst_n low mid-job aborts it. No partial block is emitted; counters clear.
//  - Counter increment across blocks is the caller's job; the engine never modifies counter.
// CONFIGURATION
//  CHACHA_HCHACHA_EN defined:
//    - adds input port hchacha (1 bit), sampled on the accepting edge.
//    - When set, FFWD is skipped and keystream[255:0] = {w15,w14,w13,w12,w3,w2,w1,w0} of the permuted state; keystream[511:256] = 0.
//    - Words 12..15 come from counter/nonce as usual (128-bit HChaCha nonce).
//    - Latency is unchanged.
//  CHACHA_HCHACHA_EN undefined: the port is absent; always ChaCha feed-forward output.
// STRUCTURE
//  - chacha_pkg: word_t, state_t (word_t[16]), CHACHA_CONST[4], QR_IDX[8][4] schedule table, fsm_t enum {IDLE,ROUND,FFWD,OUT}.
//  - Sub-module chacha_qr: combinational single quarter round, word_t a,b,c,d in/out; LANES instances via generate.
// TESTING
//  1. chacha_qr alone: a=11111111 b=01020304 c=9b8d6f43 d=01234567 -> ea2a92f4 cb1cf8ce 4581472e 5881c4bb.
//  2. key=00..1f bytes, nonce=000000090000004a00000000, counter=1, defaults:
//     out_valid at edge 22; w0..3 = e4e7f110 15593bd1 1fdd0f50 c47120a3; w15 = 4e3c50a2; blocks_done=1.
//  3. Vector 2 with LANES=1 and LANES=2 -> identical keystream; latency 82 and 42 edges.
//  4. out_ready held low 10 cycles after out_valid -> keystream stable, in_ready=0, blocks_done unchanged.
//     Then a back-to-back job accepted the same cycle out_ready rises.
//  5. rst_n pulsed low at round step 7 -> all outputs 0 asynchronously, FSM IDLE.
//     Next job yields the correct vector-2 result.
//  6. blocks_done preset near wrap (CNT_W=4, 17 jobs) -> value 1 after job 17.
//     With CHACHA_HCHACHA_EN: compare against the XChaCha draft HChaCha20 vector.

Source files
------------

// File: rtl/chacha_pkg.sv
// Shared ChaCha types, the sigma constants and the 8-entry quarter-round schedule.
package chacha_pkg;

  typedef logic [31:0] word_t;
  typedef word_t [15:0] state_t;

  typedef enum logic [1:0] {StIdle, StRound, StFfwd, StOut} fsm_t;

  localparam word_t CHACHA_CONST [4] = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574};

  // Entries 0..3 are columns, 4..7 diagonals; each row is (a, b, c, d) word indices.
  localparam logic [3:0] QR_IDX [8][4] = '{
    '{4'd0, 4'd4, 4'd8,  4'd12},
    '{4'd1, 4'd5, 4'd9,  4'd13},
    '{4'd2, 4'd6, 4'd10, 4'd14},
    '{4'd3, 4'd7, 4'd11, 4'd15},
    '{4'd0, 4'd5, 4'd10, 4'd15},
    '{4'd1, 4'd6, 4'd11, 4'd12},
    '{4'd2, 4'd7, 4'd8,  4'd13},
    '{4'd3, 4'd4, 4'd9,  4'd14}
  };

  function automatic word_t rotl(input word_t x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

endpackage

// File: rtl/chacha_qr.sv
// Combinational ChaCha quarter round on four 32-bit words.
module chacha_qr
  import chacha_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  word_t c,
  input  word_t d,
  output word_t a_res,
  output word_t b_res,
  output word_t c_res,
  output word_t d_res
);

  word_t a1, b1, c1, d1;
  word_t a2, b2, c2, d2;

  assign a1 = a + b;
  assign d1 = rotl(d ^ a1, 16);
  assign c1 = c + d1;
  assign b1 = rotl(b ^ c1, 12);
  assign a2 = a1 + b1;
  assign d2 = rotl(d1 ^ a2, 8);
  assign c2 = c1 + d2;
  assign b2 = rotl(b1 ^ c2, 7);

  assign a_res = a2;
  assign b_res = b2;
  assign c_res = c2;
  assign d_res = d2;

endmodule

// File: rtl/chacha_block_engine.sv
// ChaCha block engine: LANES quarter rounds per cycle, feed-forward, valid/ready output.
// Optional HChaCha output mode is built when CHACHA_HCHACHA_EN is defined.
module chacha_block_engine
  import chacha_pkg::*;
#(
  parameter int unsigned DOUBLE_ROUNDS = 10,
  parameter int unsigned LANES         = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [255:0]     key,
  input  logic [95:0]      nonce,
  input  logic [31:0]      counter,
`ifdef CHACHA_HCHACHA_EN
  input  logic             hchacha,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [511:0]     keystream,
  output logic             busy,
  output logic [CNT_W-1:0] blocks_done
);

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("chacha_block_engine: LANES must be 1, 2 or 4");
  end
  if (DOUBLE_ROUNDS < 1) begin : g_bad_rounds
    $error("chacha_block_engine: DOUBLE_ROUNDS must be >= 1");
  end

  localparam int unsigned R     = DOUBLE_ROUNDS * 8 / LANES;
  localparam int unsigned StepW = (R > 1) ? $clog2(R) : 1;

  fsm_t               state_q, state_d;
  logic [StepW-1:0]   step_q, step_d;
  logic [2:0]         sched_q, sched_d;
  state_t             work_q, work_d;
  state_t             save_q, save_d;
  logic [511:0]       keystream_q, keystream_d;
  logic               out_valid_q, out_valid_d;
  logic [CNT_W-1:0]   blocks_q, blocks_d;
`ifdef CHACHA_HCHACHA_EN
  logic               hch_q, hch_d;
`endif

  logic               accept, handoff;
  state_t             init_state, work_rnd, sum;
  logic [511:0]       ks_next;
  logic [3:0]         idx [LANES][4];
  word_t              res [LANES][4];

  assign in_ready    = (state_q == StIdle) || ((state_q == StOut) && out_ready);
  assign accept      = in_valid && in_ready;
  assign handoff     = out_valid_q && out_ready;
  assign busy        = (state_q != StIdle);
  assign out_valid   = out_valid_q;
  assign keystream   = keystream_q;
  assign blocks_done = blocks_q;

  always_comb begin
    init_state = '0;
    for (int i = 0; i < 4; i++) init_state[i] = CHACHA_CONST[i];
    for (int k = 0; k < 8; k++) init_state[4 + k] = key[32*k +: 32];
    init_state[12] = counter;
    for (int n = 0; n < 3; n++) init_state[13 + n] = nonce[32*n +: 32];
  end

  // Lanes within one step pick consecutive schedule entries, so they never share a word.
  for (genvar lane = 0; lane < LANES; lane++) begin : g_lane
    logic [2:0] ent;
    assign ent = sched_q + 3'(lane);
    for (genvar j = 0; j < 4; j++) begin : g_idx
      assign idx[lane][j] = QR_IDX[ent][j];
    end
    chacha_qr u_qr (
      .a     (work_q[idx[lane][0]]),
      .b     (work_q[idx[lane][1]]),
      .c     (work_q[idx[lane][2]]),
      .d     (work_q[idx[lane][3]]),
      .a_res (res[lane][0]),
      .b_res (res[lane][1]),
      .c_res (res[lane][2]),
      .d_res (res[lane][3])
    );
  end

  always_comb begin
    work_rnd = work_q;
    for (int l = 0; l < int'(LANES); l++) begin
      for (int j = 0; j < 4; j++) work_rnd[idx[l][j]] = res[l][j];
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < 16; i++) sum[i] = work_q[i] + save_q[i];
  end

`ifdef CHACHA_HCHACHA_EN
  assign ks_next = hch_q ? {256'b0, work_q[15], work_q[14], work_q[13], work_q[12],
                            work_q[3], work_q[2], work_q[1], work_q[0]}
                         : sum;
`else
  assign ks_next = sum;
`endif

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    sched_d     = sched_q;
    work_d      = work_q;
    save_d      = save_q;
    keystream_d = keystream_q;
    out_valid_d = out_valid_q;
    blocks_d    = blocks_q;
`ifdef CHACHA_HCHACHA_EN
    hch_d       = hch_q;
`endif

    if (handoff) begin
      out_valid_d = 1'b0;
      blocks_d    = blocks_q + CNT_W'(1);
    end

    // Inputs are only sampled here, on the accepting edge.
    if (accept) begin
      state_d = StRound;
      step_d  = '0;
      sched_d = '0;
      work_d  = init_state;
      save_d  = init_state;
`ifdef CHACHA_HCHACHA_EN
      hch_d   = hchacha;
`endif
    end else begin
      unique case (state_q)
        StIdle: ;
        StRound: begin
          work_d  = work_rnd;
          step_d  = step_q + StepW'(1);
          sched_d = sched_q + 3'(LANES);
          if (step_q == StepW'(R - 1)) state_d = StFfwd;
        end
        StFfwd: begin
          keystream_d = ks_next;
          out_valid_d = 1'b1;
          state_d     = StOut;
        end
        StOut: begin
          if (out_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      step_q      <= '0;
      sched_q     <= '0;
      work_q      <= '0;
      save_q      <= '0;
      keystream_q <= '0;
      out_valid_q <= 1'b0;
      blocks_q    <= '0;
`ifdef CHACHA_HCHACHA_EN
      hch_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      sched_q     <= sched_d;
      work_q      <= work_d;
      save_q      <= save_d;
      keystream_q <= keystream_d;
      out_valid_q <= out_valid_d;
      blocks_q    <= blocks_d;
`ifdef CHACHA_HCHACHA_EN
      hch_q       <= hch_d;
`endif
    end
  end

endmodule

// File: tb/tb_chacha_block_engine.sv
// Directed bench for chacha_block_engine: three lane configurations, reference model scoreboard.
module tb_chacha_block_engine;

  logic         clk;
  logic         rst_n;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  ctr;
  logic         hch;

  logic         in_valid  [3];
  logic         out_ready [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic         busy      [3];
  logic [511:0] ks        [3];
  logic [15:0]  bd        [3];
  logic [3:0]   bd1;

  logic [31:0]  qa, qb, qc, qd, ra, rb, rc, rd;

  logic [511:0] sb_q [$];
  logic [511:0] exp_ks;
  int           total, bad, lat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bd[1] = {12'b0, bd1};

  chacha_block_engine u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .key(key), .nonce(nonce), .counter(ctr),
`ifdef CHACHA_HCHACHA_EN
    .hchacha(hch),
`endif
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .keystream(ks[0]),
    .busy(busy[0]), .blocks_done(bd[0])
  );

  chacha_block_engine #(.DOUBLE_ROUNDS(10), .LANES(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .key(key), .nonce(nonce), .counter(ctr),
`ifdef CHACHA_HCHACHA_EN
    .hchacha(hch),
`endif
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .keystream(ks[1]),
    .busy(busy[1]), .blocks_done(bd1)
  );

  chacha_block_engine #(.DOUBLE_ROUNDS(10), .LANES(2), .CNT_W(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .key(key), .nonce(nonce), .counter(ctr),
`ifdef CHACHA_HCHACHA_EN
    .hchacha(hch),
`endif
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .keystream(ks[2]),
    .busy(busy[2]), .blocks_done(bd[2])
  );

  chacha_qr u_qr (
    .a(qa), .b(qb), .c(qc), .d(qd), .a_res(ra), .b_res(rb), .c_res(rc), .d_res(rd)
  );

  function automatic logic [127:0] mqr(input logic [31:0] a, b, c, d);
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] model(input logic [255:0] k, input logic [95:0] n,
                                         input logic [31:0] c, input int dr, input logic h);
    logic [31:0]  s [16];
    logic [31:0]  w [16];
    logic [511:0] o;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4 + i] = k[32*i +: 32];
    s[12] = c;
    for (int i = 0; i < 3; i++) s[13 + i] = n[32*i +: 32];
    w = s;
    for (int r = 0; r < dr; r++) begin
      for (int i = 0; i < 4; i++)
        {w[i], w[4 + i], w[8 + i], w[12 + i]} = mqr(w[i], w[4 + i], w[8 + i], w[12 + i]);
      for (int i = 0; i < 4; i++)
        {w[i], w[4 + (i + 1) % 4], w[8 + (i + 2) % 4], w[12 + (i + 3) % 4]} =
          mqr(w[i], w[4 + (i + 1) % 4], w[8 + (i + 2) % 4], w[12 + (i + 3) % 4]);
    end
    o = '0;
    if (h) o[255:0] = {w[15], w[14], w[13], w[12], w[3], w[2], w[1], w[0]};
    else for (int i = 0; i < 16; i++) o[32*i +: 32] = w[i] + s[i];
    return o;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input int d);
    int guard;
    guard = 0;
    @(negedge clk);
    in_valid[d] = 1'b1;
    while (!in_ready[d] && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_timeout", 512'(guard < 200), 512'(1));
    sb_q.push_back(model(key, nonce, ctr, 10, hch));
    @(posedge clk);
    #1 in_valid[d] = 1'b0;
  endtask

  // lat counts edges after the accepting edge until out_valid is visible.
  task automatic wait_out(input int d, output int l);
    l = 0;
    while (!out_valid[d] && l < 300) begin
      @(posedge clk);
      #1 l++;
    end
    chk("out_valid_timeout", 512'(out_valid[d]), 512'(1));
  endtask

  task automatic take_out(input int d, input string tag);
    logic [511:0] e;
    e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    chk({tag, "_ks"}, ks[d], e);
    @(negedge clk);
    out_ready[d] = 1'b1;
    @(posedge clk);
    #1 out_ready[d] = 1'b0;
  endtask

  task automatic set_vec2();
    for (int i = 0; i < 32; i++) key[8*i +: 8] = 8'(i);
    nonce = {32'h00000000, 32'h4a000000, 32'h09000000};
    ctr   = 32'd1;
    hch   = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
    end
    key = '0; nonce = '0; ctr = '0; hch = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 512'(out_valid[0]), 512'(0));
    chk("rst_busy", 512'(busy[0]), 512'(0));
    chk("rst_keystream", ks[0], '0);
    chk("rst_blocks", 512'(bd[0]), 512'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 512'(in_ready[0]), 512'(1));

    // Quarter round alone.
    qa = 32'h11111111; qb = 32'h01020304; qc = 32'h9b8d6f43; qd = 32'h01234567;
    #1;
    chk("qr_vector", 512'({ra, rb, rc, rd}),
        512'({32'hea2a92f4, 32'hcb1cf8ce, 32'h4581472e, 32'h5881c4bb}));

    // Reference vector on the default engine.
    set_vec2();
    start_job(0);
    chk("busy_running", 512'(busy[0]), 512'(1));
    wait_out(0, lat);
    chk("lat_lanes4", 512'(lat + 1), 512'(22));
    chk("vec2_w0_3", 512'(ks[0][127:0]),
        512'({32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110}));
    chk("vec2_w15", 512'(ks[0][511:480]), 512'(32'h4e3c50a2));
    take_out(0, "vec2");
    chk("vec2_blocks", 512'(bd[0]), 512'(1));
    chk("vec2_valid_drop", 512'(out_valid[0]), 512'(0));

    // Narrower lane configurations produce the same block, later.
    start_job(1);
    wait_out(1, lat);
    chk("lat_lanes1", 512'(lat + 1), 512'(82));
    take_out(1, "lanes1");
    start_job(2);
    wait_out(2, lat);
    chk("lat_lanes2", 512'(lat + 1), 512'(42));
    take_out(2, "lanes2");

    // Backpressure, then a back-to-back accept on the releasing edge.
    ctr = 32'd2;
    start_job(0);
    wait_out(0, lat);
    exp_ks = sb_q[0];
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("hold_ks", ks[0], exp_ks);
      chk("hold_in_ready", 512'(in_ready[0]), 512'(0));
      chk("hold_blocks", 512'(bd[0]), 512'(1));
    end
    @(negedge clk);
    chk("b2b_ks", ks[0], sb_q.pop_front());
    ctr          = 32'd3;
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b1;
    #1;
    chk("b2b_in_ready", 512'(in_ready[0]), 512'(1));
    sb_q.push_back(model(key, nonce, ctr, 10, hch));
    @(posedge clk);
    #1;
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    chk("b2b_blocks", 512'(bd[0]), 512'(2));
    chk("b2b_valid_drop", 512'(out_valid[0]), 512'(0));
    chk("b2b_busy", 512'(busy[0]), 512'(1));
    wait_out(0, lat);
    chk("b2b_lat", 512'(lat + 1), 512'(22));
    take_out(0, "b2b");
    chk("b2b_blocks2", 512'(bd[0]), 512'(3));

    // Asynchronous abort mid-round.
    set_vec2();
    start_job(0);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    void'(sb_q.pop_front());
    chk("abort_ks", ks[0], '0);
    chk("abort_valid", 512'(out_valid[0]), 512'(0));
    chk("abort_busy", 512'(busy[0]), 512'(0));
    chk("abort_blocks0", 512'(bd[0]), 512'(0));
    chk("abort_blocks1", 512'(bd[1]), 512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    start_job(0);
    wait_out(0, lat);
    chk("after_abort_lat", 512'(lat + 1), 512'(22));
    take_out(0, "after_abort");
    chk("after_abort_blocks", 512'(bd[0]), 512'(1));

    // Counter wrap on the 4-bit instance.
    for (int j = 1; j <= 17; j++) begin
      ctr = 32'(j);
      start_job(1);
      wait_out(1, lat);
      take_out(1, "wrap_job");
      if (j == 15) chk("wrap_15", 512'(bd[1]), 512'(15));
      if (j == 16) chk("wrap_16", 512'(bd[1]), 512'(0));
    end
    chk("wrap_17", 512'(bd[1]), 512'(1));

`ifdef CHACHA_HCHACHA_EN
    // HChaCha20 draft vector.
    for (int i = 0; i < 32; i++) key[8*i +: 8] = 8'(i);
    ctr   = 32'h09000000;
    nonce = {32'h27594131, 32'h00000000, 32'h4a000000};
    hch   = 1'b1;
    start_job(0);
    wait_out(0, lat);
    chk("hchacha_lat", 512'(lat + 1), 512'(22));
    chk("hchacha_vec", ks[0], 512'({32'hdcecd326, 32'h13c42ec1, 32'h53a8748a, 32'hd5e4f9a0,
                                     32'h737d878a, 32'h50420ed3, 32'hfe7bb227, 32'h423b4182}));
    take_out(0, "hchacha");
    hch = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
